// File: rtl/sc_ram_pkg.sv
// rtl/sc_ram_pkg.sv - shared constants and elaboration helpers for the sc_ram family
package sc_ram_pkg;

  localparam int RDW_OLD_DATA = 0;
  localparam int RDW_NEW_DATA = 1;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  function automatic bit rd_latency_legal(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

  function automatic bit rdw_mode_legal(input int mode);
    return (mode == RDW_OLD_DATA) || (mode == RDW_NEW_DATA);
  endfunction

endpackage

// File: rtl/sc_ram_out_pipe.sv
// rtl/sc_ram_out_pipe.sv - valid/data delay line, data registers load only on incoming valid
module sc_ram_out_pipe #(
  parameter int DWIDTH = 16,
  parameter int STAGES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_data
);

  // Element 0 is the input; with STAGES=0 the chain collapses to a pass-through.
  logic [STAGES:0]   w_valid;
  logic [DWIDTH-1:0] w_data [STAGES+1];

  assign w_valid[0] = i_valid;
  assign w_data[0]  = i_data;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              r_valid;
    logic [DWIDTH-1:0] r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= w_valid[s];
        if (w_valid[s]) begin
          r_data <= w_data[s];
        end
      end
    end

    assign w_valid[s+1] = r_valid;
    assign w_data[s+1]  = r_data;
  end

  assign o_valid = w_valid[STAGES];
  assign o_data  = w_data[STAGES];

endmodule

// File: rtl/sc_ram_be_pipe.sv
// rtl/sc_ram_be_pipe.sv - simple dual-port RAM with byte enables, RDW policy and read pipeline
module sc_ram_be_pipe
  import sc_ram_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 4,
  parameter int BWIDTH     = 8,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [AWIDTH-1:0]        wr_addr_i,
  input  logic [DWIDTH-1:0]        wr_data_i,
  input  logic [DWIDTH/BWIDTH-1:0] wr_be_i,
  input  logic                     rd_en_i,
  input  logic [AWIDTH-1:0]        rd_addr_i,
  output logic [DWIDTH-1:0]        rd_data_o,
  output logic                     rd_valid_o
);

  localparam int NBYTES = DWIDTH / BWIDTH;
  localparam int DEPTH  = 2 ** AWIDTH;

  if (DWIDTH % BWIDTH != 0) begin : g_bad_bwidth
    $fatal(1, "sc_ram_be_pipe: DWIDTH must be a multiple of BWIDTH");
  end
  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $fatal(1, "sc_ram_be_pipe: RD_LATENCY must be in 1..4");
  end
  if (!rdw_mode_legal(RDW_MODE)) begin : g_bad_rdw_mode
    $fatal(1, "sc_ram_be_pipe: RDW_MODE must be 0 or 1");
  end

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] w_be_mask;
  logic [DWIDTH-1:0] w_rd_old;
  logic [DWIDTH-1:0] w_rd_merged;
  logic              w_rdw_hit;
  logic [DWIDTH-1:0] w_s1_next;
  logic              r_s1_valid;
  logic [DWIDTH-1:0] r_s1_data;

  for (genvar k = 0; k < NBYTES; k++) begin : g_be_mask
    assign w_be_mask[k*BWIDTH +: BWIDTH] = {BWIDTH{wr_be_i[k]}};
  end

  // Array is deliberately not reset so contents survive rst_ni; writes are only gated by it.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en_i) begin
      r_mem[wr_addr_i] <= (r_mem[wr_addr_i] & ~w_be_mask) | (wr_data_i & w_be_mask);
    end
  end

  assign w_rd_old    = r_mem[rd_addr_i];
  assign w_rd_merged = (w_rd_old & ~w_be_mask) | (wr_data_i & w_be_mask);
  assign w_rdw_hit   = wr_en_i && (rd_addr_i == wr_addr_i);
  assign w_s1_next   = ((RDW_MODE == RDW_NEW_DATA) && w_rdw_hit) ? w_rd_merged : w_rd_old;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= rd_en_i;
      if (rd_en_i) begin
        r_s1_data <= w_s1_next;
      end
    end
  end

  sc_ram_out_pipe #(
    .DWIDTH (DWIDTH),
    .STAGES (RD_LATENCY - 1)
  ) u_out_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_valid (r_s1_valid),
    .i_data  (r_s1_data),
    .o_valid (rd_valid_o),
    .o_data  (rd_data_o)
  );

endmodule

// File: tb/tb_sc_ram_be_pipe.sv
// tb/tb_sc_ram_be_pipe.sv - scoreboard bench over four latency/RDW configurations
module tb_sc_ram_be_pipe;

  localparam int NINST = 4;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data  [NINST];
  logic        rd_valid [NINST];

  typedef struct {
    int          inst;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model [16];
  logic [15:0] last  [NINST];
  int          cyc;
  int          checks;
  int          errors;
  bit          mon_en;

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 1;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int mode_of(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction

  sc_ram_be_pipe #(.DWIDTH(16), .AWIDTH(4), .BWIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)) u_l1_old (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]));
  sc_ram_be_pipe #(.DWIDTH(16), .AWIDTH(4), .BWIDTH(8), .RD_LATENCY(1), .RDW_MODE(1)) u_l1_new (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]));
  sc_ram_be_pipe #(.DWIDTH(16), .AWIDTH(4), .BWIDTH(8), .RD_LATENCY(3), .RDW_MODE(0)) u_l3_old (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]));
  sc_ram_be_pipe #(.DWIDTH(16), .AWIDTH(4), .BWIDTH(8), .RD_LATENCY(4), .RDW_MODE(1)) u_l4_new (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[3]), .rd_valid_o(rd_valid[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output side of the scoreboard: each instance must show exactly the responses due this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NINST; i++) begin
        bit          found;
        logic [15:0] ed;
        found = 1'b0;
        ed    = '0;
        for (int j = 0; j < sb.size(); j++) begin
          if (sb[j].inst == i && sb[j].due == cyc) begin
            found = 1'b1;
            ed    = sb[j].data;
          end
        end
        checks++;
        if (rd_valid[i] !== found) begin
          errors++;
          $display("FAIL sb_valid inst%0d cyc%0d: got %b want %b", i, cyc, rd_valid[i], found);
        end else begin
          checks++;
          if (found) begin
            if (rd_data[i] !== ed) begin
              errors++;
              $display("FAIL sb_data inst%0d cyc%0d: got %h want %h", i, cyc, rd_data[i], ed);
            end
            last[i] = ed;
          end else if (rd_data[i] !== last[i]) begin
            errors++;
            $display("FAIL sb_hold inst%0d cyc%0d: got %h want %h", i, cyc, rd_data[i], last[i]);
          end
        end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due <= cyc) sb.delete(j);
      end
    end
  end

  // Drive one cycle of stimulus; called at posedge+1 and returns at the next posedge+1.
  task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic re, input logic [3:0] ra);
    logic [15:0] wmerged;
    logic [15:0] rmerged;
    logic [15:0] old;
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    old        = model[wa];
    wmerged    = old;
    wmerged[7:0]  = be[0] ? wd[7:0]  : old[7:0];
    wmerged[15:8] = be[1] ? wd[15:8] : old[15:8];
    if (re) begin
      for (int i = 0; i < NINST; i++) begin
        rmerged = model[ra];
        if (mode_of(i) == 1 && we && wa == ra) rmerged = wmerged;
        sb.push_back('{inst: i, data: rmerged, due: cyc + lat_of(i)});
      end
    end
    if (we) model[wa] = wmerged;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, 16'd0, 2'b00, 1'b0, 4'd0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) begin
      checks++;
      if (rd_valid[i] !== 1'b0 || rd_data[i] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_state inst%0d: got v=%b d=%h want v=0 d=0000", i, rd_valid[i], rd_data[i]);
      end
      last[i] = '0;
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(1);
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'(i), 2'b11, 1'b0, 4'd0);
  endtask

  task automatic test_stream;
    int ones;
    int first;
    ones  = 0;
    first = -1;
    for (int s = 0; s < 22; s++) begin
      if (s < 16) step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'(s));
      else        idle(1);
      checks++;
      if (rd_valid[2] !== ((s >= 2) && (s <= 17))) begin
        errors++;
        $display("FAIL stream_valid step%0d: got %b want %b", s, rd_valid[2], (s >= 2) && (s <= 17));
      end
      if (rd_valid[2] === 1'b1) begin
        ones++;
        if (first < 0) first = s;
      end
    end
    checks++;
    if (ones != 16 || first != 2) begin
      errors++;
      $display("FAIL stream_run: got count=%0d first=%0d want count=16 first=2", ones, first);
    end
    checks++;
    if (rd_valid[2] !== 1'b0 || rd_data[2] !== 16'h000F) begin
      errors++;
      $display("FAIL stream_hold: got v=%b d=%h want v=0 d=000f", rd_valid[2], rd_data[2]);
    end
  endtask

  task automatic test_basic;
    step(1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3);
    checks++;
    if (rd_valid[0] !== 1'b1 || rd_data[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL basic_read: got v=%b d=%h want v=1 d=beef", rd_valid[0], rd_data[0]);
    end
    idle(4);
  endtask

  task automatic test_byte_enables;
    step(1'b1, 4'd5, 16'h1234, 2'b11, 1'b0, 4'd0);
    step(1'b1, 4'd5, 16'hAB00, 2'b10, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd5);
    checks++;
    if (rd_data[0] !== 16'hAB34) begin
      errors++;
      $display("FAIL be_upper: got %h want ab34", rd_data[0]);
    end
    step(1'b1, 4'd5, 16'hFFFF, 2'b00, 1'b0, 4'd0);
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd5);
    checks++;
    if (rd_data[0] !== 16'hAB34) begin
      errors++;
      $display("FAIL be_none: got %h want ab34", rd_data[0]);
    end
    idle(4);
  endtask

  task automatic test_rdw;
    step(1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0);
    step(1'b1, 4'd7, 16'h2222, 2'b11, 1'b1, 4'd7);
    checks++;
    if (rd_data[0] !== 16'h1111 || rd_data[1] !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_full: got old=%h new=%h want old=1111 new=2222", rd_data[0], rd_data[1]);
    end
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd7);
    checks++;
    if (rd_data[0] !== 16'h2222) begin
      errors++;
      $display("FAIL rdw_after: got %h want 2222", rd_data[0]);
    end
    step(1'b1, 4'd7, 16'h1111, 2'b11, 1'b0, 4'd0);
    step(1'b1, 4'd7, 16'h2222, 2'b01, 1'b1, 4'd7);
    checks++;
    if (rd_data[0] !== 16'h1111 || rd_data[1] !== 16'h1122) begin
      errors++;
      $display("FAIL rdw_partial: got old=%h new=%h want old=1111 new=1122", rd_data[0], rd_data[1]);
    end
    idle(4);
  endtask

  task automatic test_diff_addr;
    step(1'b1, 4'd9, 16'h5A5A, 2'b11, 1'b0, 4'd0);
    step(1'b1, 4'd2, 16'h0F0F, 2'b11, 1'b1, 4'd9);
    checks++;
    if (rd_data[1] !== 16'h5A5A) begin
      errors++;
      $display("FAIL diff_addr_read: got %h want 5a5a", rd_data[1]);
    end
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd2);
    checks++;
    if (rd_data[1] !== 16'h0F0F) begin
      errors++;
      $display("FAIL diff_addr_after: got %h want 0f0f", rd_data[1]);
    end
    idle(4);
  endtask

  task automatic test_reset_flush;
    int pulses;
    pulses = 0;
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3);
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd5);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < NINST; i++) last[i] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < 6; s++) begin
      idle(1);
      if (rd_valid[3] === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || rd_data[3] !== 16'h0000) begin
      errors++;
      $display("FAIL flush: got pulses=%0d d=%h want pulses=0 d=0000", pulses, rd_data[3]);
    end
    step(1'b0, 4'd0, 16'd0, 2'b00, 1'b1, 4'd3);
    idle(3);
    checks++;
    if (rd_valid[3] !== 1'b1 || rd_data[3] !== 16'hBEEF) begin
      errors++;
      $display("FAIL preserved: got v=%b d=%h want v=1 d=beef", rd_valid[3], rd_data[3]);
    end
    idle(3);
  endtask

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < NINST; i++) last[i] = '0;
    test_reset;
    test_fill;
    test_stream;
    test_basic;
    test_byte_enables;
    test_rdw;
    test_diff_addr;
    test_reset_flush;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_ram_be_pipe.md
Name: sc_ram_be_pipe

Overview:
Simple dual-port synchronous RAM: one write port, one read port, one clock. Adds per-byte write enables, explicit read/write enables, a selectable read-during-write policy and a configurable read-latency pipeline with a valid strobe. It is the storage primitive for the next FIFO generation and for other buffering blocks that need byte-granular writes or a deeper read pipeline for timing.

Parameters:
DWIDTH, 16, data word width; must be a multiple of BWIDTH.
AWIDTH, 4, address width; depth = 2**AWIDTH words.
BWIDTH, 8, byte-lane width; NBYTES = DWIDTH/BWIDTH.
RD_LATENCY, 1, cycles from read request to data; legal range 1..4.
RDW_MODE, 0, same-address read-during-write policy: 0 = OLD_DATA, 1 = NEW_DATA.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_ni  in  1  asynchronous active-low reset.
wr_en_i  in  1  write request this cycle.
wr_addr_i  in  AWIDTH  write address.
wr_data_i  in  DWIDTH  write data.
wr_be_i  in  NBYTES  byte enables; bit k covers wr_data_i[k*BWIDTH +: BWIDTH].
rd_en_i  in  1  read request this cycle.
rd_addr_i  in  AWIDTH  read address.
rd_data_o  out  DWIDTH  read data; registered.
rd_valid_o  out  1  rd_data_o carries the response to a request.

Behaviour:
- Reset (rst_ni low, async): all pipeline valid bits and rd_valid_o -> 0; all pipeline data registers and rd_data_o -> 0. Memory array is not reset; contents preserved.
- While rst_ni low: writes and reads suppressed. In-flight reads are flushed, never delivered.
- Write: at a rising edge with wr_en_i=1, byte k of mem[wr_addr_i] is updated iff wr_be_i[k]=1. wr_be_i all-zero leaves the word unchanged. wr_en_i=0 means no change.
- Read: request at edge t (rd_en_i=1) -> rd_valid_o=1 and data valid after edge t+RD_LATENCY-1, i.e. visible in cycle t+RD_LATENCY. RD_LATENCY=1 matches a plain registered-output RAM.
- Pipeline: stage 1 samples the array (plus the bypass mux); stages 2..RD_LATENCY are valid/data register pairs.
- A stage's data register loads only when its incoming valid is 1. rd_data_o therefore holds the last delivered word while rd_valid_o=0.
- Back-to-back reads are accepted every cycle with full throughput. There is no backpressure.
- Read-during-write applies when rd_en_i, wr_en_i and rd_addr_i==wr_addr_i are all true at the same edge:
  - OLD_DATA: returns the pre-write word.
  - NEW_DATA: returns a merged word: byte k = wr_data_i byte if wr_be_i[k], else the old memory byte.
- Different addresses in the same cycle: no interaction.
- A read at any edge after a write always sees the written bytes.
- Address wrap: addresses are unsigned AWIDTH bits; no out-of-range case exists.
- Elaboration: DWIDTH % BWIDTH != 0, RD_LATENCY outside 1..4, or RDW_MODE outside {0,1} -> $fatal at elaboration.

Decomposition:
- Package sc_ram_pkg holds:
  - localparams RDW_OLD_DATA=0 and RDW_NEW_DATA=1;
  - function be_merge(old, new, be), parametrised through the caller's widths via a let/param class or inlined per instance.
- Sub-module sc_ram_out_pipe(DWIDTH, STAGES) is the valid/data delay line with async reset and load-on-valid. It is instantiated with STAGES = RD_LATENCY-1; STAGES=0 is a pass-through.

Test Plan:
1. RD_LATENCY=1. Write 0xBEEF to addr 3 with be=2'b11; read addr 3 next cycle -> rd_valid_o=1 exactly one cycle after rd_en_i, rd_data_o=0xBEEF.
2. Byte enables. Write 0x1234 to addr 5 (be=11), then 0xAB00 with be=2'b10; read 5 -> 0xAB34. Then write with be=2'b00 and read 5 -> still 0xAB34.
3. Read-during-write. addr 7 holds 0x1111; same-edge write 0x2222 (be=11) and read 7:
   - OLD_DATA -> 0x1111, next read -> 0x2222;
   - NEW_DATA -> 0x2222;
   - NEW_DATA with be=2'b01 -> 0x1122.
4. RD_LATENCY=3. Reads of addr 0..15 on 16 consecutive cycles (mem[i]=i) -> rd_valid_o high for 16 consecutive cycles starting 3 cycles after the first request, data 0..15 in order. After the stream, rd_data_o holds 15 with rd_valid_o=0.
5. Reset mid-operation. RD_LATENCY=4, issue 2 reads, assert rst_ni low for 1 cycle before delivery -> rd_valid_o never pulses, rd_data_o=0. After release, a read of a previously written address returns the preserved value.
6. Simultaneous write and read to different addresses: write addr 2=0x0F0F while reading addr 9=0x5A5A -> read returns 0x5A5A, and a subsequent read of addr 2 returns 0x0F0F.
